// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN channel types and constants
package can_pkg;

  typedef enum logic [2:0] {
    s_idle   = 3'd0,
    s_wait   = 3'd1,
    s_sample = 3'd2,
    s_eval   = 3'd3,
    s_done   = 3'd4,
    s_lost   = 3'd5,
    s_error  = 3'd6
  } idTxState_t;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  localparam int STUFF_LEN_DEFAULT = 5;

endpackage

// File: rtl/bit_stuffer.sv
// rtl/bit_stuffer.sv - run-length tracker that requests a stuff bit
module bit_stuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic bitValid,
  input  logic bitValue,
  input  logic isStuff,
  input  logic clear,
  output logic stuffPending
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic             lastBit;
  logic [RUN_W-1:0] runLen;
  logic [RUN_W-1:0] runNext;

  // A stuff bit always opens a fresh run; the counter saturates at STUFF_LEN.
  always_comb begin
    runNext = runLen;
    if (isStuff || (runLen == '0) || (bitValue != lastBit)) begin
      runNext = RUN_ONE;
    end else if (runLen != RUN_MAX) begin
      runNext = runLen + RUN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lastBit      <= RECESSIVE;
      runLen       <= '0;
      stuffPending <= 1'b0;
    end else if (bitValid) begin
      lastBit      <= bitValue;
      runLen       <= runNext;
      stuffPending <= (runNext == RUN_MAX);
    end
  end

endmodule

// File: rtl/id_transmitter.sv
// rtl/id_transmitter.sv - CAN SOF+identifier transmitter with stuffing and read-back
module id_transmitter
  import can_pkg::*;
#(
  parameter int ID_BITS   = 11,
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [ID_BITS-1:0] id,
  input  logic               bitStart,
  input  logic               samplePulse,
  input  logic               dIn,
  output logic               dOut,
  output logic               busy,
  output logic               txDone,
  output logic               arbLost,
  output logic               bitError,
  output logic [5:0]         DBG
);

  localparam int CNT_W = $clog2(ID_BITS + 2);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ID_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  idTxState_t         state;
  logic [ID_BITS-1:0] shiftReg;
  logic [CNT_W-1:0]   bitCount;
  logic [1:0]         sampleCnt;
  logic [1:0]         samples;
  logic               txBit;
  logic               isStuff;
  logic               majority;
  logic               stuffPending;
  logic               thirdPulse;
  logic               vote;
  logic               bitValid;
  logic               stuffClear;

  // The vote closes on the third pulse itself so the stuff tracker and bit
  // counter are already current when s_eval decides whether the frame is done.
  assign thirdPulse = (state == s_sample) && samplePulse && (sampleCnt == 2'd2);
  assign vote       = (samples[1] & samples[0]) | (samples[1] & dIn) | (samples[0] & dIn);
  assign bitValid   = thirdPulse && !bitStart ? (vote == txBit) : 1'b0;
  assign stuffClear = (state == s_idle) && enable && start;

  bit_stuffer #(
    .STUFF_LEN(STUFF_LEN)
  ) u_stuffer (
    .clk         (clk),
    .reset       (reset),
    .bitValid    (bitValid),
    .bitValue    (txBit),
    .isStuff     (isStuff),
    .clear       (stuffClear),
    .stuffPending(stuffPending)
  );

  assign DBG = {state, stuffPending, majority, txBit};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= s_idle;
      shiftReg  <= '0;
      bitCount  <= '0;
      sampleCnt <= '0;
      samples   <= '0;
      txBit     <= 1'b0;
      isStuff   <= 1'b0;
      majority  <= 1'b0;
      dOut      <= RECESSIVE;
      busy      <= 1'b0;
      txDone    <= 1'b0;
      arbLost   <= 1'b0;
      bitError  <= 1'b0;
    end else begin
      txDone   <= 1'b0;
      arbLost  <= 1'b0;
      bitError <= 1'b0;
      case (state)
        s_idle: begin
          dOut <= RECESSIVE;
          busy <= 1'b0;
          if (enable && start) begin
            shiftReg  <= id;
            bitCount  <= '0;
            sampleCnt <= '0;
            isStuff   <= 1'b0;
            busy      <= 1'b1;
            state     <= s_wait;
          end
        end

        s_wait: begin
          if (bitStart) begin
            sampleCnt <= '0;
            state     <= s_sample;
            if (stuffPending) begin
              txBit   <= ~txBit;
              dOut    <= ~txBit;
              isStuff <= 1'b1;
            end else if (bitCount == '0) begin
              txBit   <= DOMINANT;
              dOut    <= DOMINANT;
              isStuff <= 1'b0;
            end else begin
              txBit    <= shiftReg[ID_BITS-1];
              dOut     <= shiftReg[ID_BITS-1];
              shiftReg <= shiftReg << 1;
              isStuff  <= 1'b0;
            end
          end
        end

        s_sample: begin
          if (bitStart && !thirdPulse) begin
            // A new bit time opened before sampling finished.
            dOut     <= RECESSIVE;
            bitError <= 1'b1;
            state    <= s_error;
          end else if (samplePulse) begin
            samples   <= {samples[0], dIn};
            sampleCnt <= sampleCnt + 2'd1;
            if (sampleCnt == 2'd2) begin
              majority <= vote;
              state    <= s_eval;
              if (bitValid && !isStuff) begin
                bitCount <= bitCount + CNT_ONE;
              end
            end
          end
        end

        s_eval: begin
          dOut <= RECESSIVE;
          if (majority != txBit) begin
            if ((txBit == RECESSIVE) && !isStuff) begin
              arbLost <= 1'b1;
              state   <= s_lost;
            end else begin
              bitError <= 1'b1;
              state    <= s_error;
            end
          end else if ((bitCount == LAST_COUNT) && !stuffPending) begin
            txDone <= 1'b1;
            state  <= s_done;
          end else begin
            dOut  <= txBit;
            state <= s_wait;
          end
        end

        s_done, s_lost, s_error: begin
          dOut  <= RECESSIVE;
          busy  <= 1'b0;
          state <= s_idle;
        end

        default: begin
          dOut  <= RECESSIVE;
          busy  <= 1'b0;
          state <= s_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_transmitter.sv
// tb/tb_id_transmitter.sv - scoreboard bench for id_transmitter
module tb_id_transmitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [10:0] id = '0;
  logic        bitStart = 1'b0;
  logic        samplePulse = 1'b0;
  logic        dIn = 1'b1;
  logic        dOut;
  logic        busy;
  logic        txDone;
  logic        arbLost;
  logic        bitError;
  logic [5:0]  DBG;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  id_transmitter #(
    .ID_BITS  (11),
    .STUFF_LEN(5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .id         (id),
    .bitStart   (bitStart),
    .samplePulse(samplePulse),
    .dIn        (dIn),
    .dOut       (dOut),
    .busy       (busy),
    .txDone     (txDone),
    .arbLost    (arbLost),
    .bitError   (bitError),
    .DBG        (DBG)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference bit sequence: SOF, id MSB first, a complement after every run of 5.
  function automatic void push_frame(input logic [10:0] fid);
    logic last;
    logic b;
    int   run;
    run  = 0;
    last = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = (i == 0) ? 1'b0 : fid[11-i];
      exp_q.push_back(b);
      run  = (run > 0 && b == last) ? run + 1 : 1;
      last = b;
      if (run == 5) begin
        exp_q.push_back(~b);
        last = ~b;
        run  = 1;
      end
    end
  endfunction

  task automatic request(input logic [10:0] fid);
    id     = fid;
    enable = 1'b1;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic bit_time(input logic [2:0] fmask, input logic fval, output logic sent);
    bitStart = 1'b1;
    step();
    bitStart = 1'b0;
    sent = dOut;
    step();
    for (int s = 0; s < 3; s++) begin
      dIn = fmask[s] ? fval : dOut;
      samplePulse = 1'b1;
      step();
      samplePulse = 1'b0;
    end
    dIn = dOut;
  endtask

  task automatic play_bits(input int nbits, input int fbit, input logic [2:0] fmask,
                           input logic fval, input string tag);
    logic exp_b;
    logic sent;
    for (int b = 0; b < nbits; b++) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s: scoreboard empty at bit %0d", tag, b);
        exp_b = 1'b1;
      end else begin
        exp_b = exp_q.pop_front();
      end
      bit_time((b == fbit) ? fmask : 3'b000, fval, sent);
      checks++;
      if (sent !== exp_b) begin
        failures++;
        $display("FAIL %s: dOut bit %0d got %b want %b", tag, b, sent, exp_b);
      end
      if (b != nbits - 1) begin
        step();
        checks++;
        if ({busy, txDone, arbLost, bitError} !== 4'b1000) begin
          failures++;
          $display("FAIL %s: mid-frame status bit %0d got %b want 1000", tag, b,
                   {busy, txDone, arbLost, bitError});
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({dOut, busy, txDone, arbLost, bitError} !== 5'b10000 || DBG !== 6'd0) begin
      failures++;
      $display("FAIL reset: outputs got %b DBG %h want 10000 DBG 00",
               {dOut, busy, txDone, arbLost, bitError}, DBG);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_frame(input logic [10:0] fid, input string tag);
    int n;
    exp_q.delete();
    push_frame(fid);
    n = exp_q.size();
    request(fid);
    enable = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b want 1", tag, busy);
    end
    play_bits(n, -1, 3'b000, 1'b0, tag);
    step();
    checks++;
    if ({txDone, arbLost, bitError, dOut} !== 4'b1001) begin
      failures++;
      $display("FAIL %s_done: txDone/arbLost/bitError/dOut got %b want 1001", tag,
               {txDone, arbLost, bitError, dOut});
    end
    step();
    checks++;
    if ({busy, txDone} !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle: busy/txDone got %b want 00", tag, {busy, txDone});
    end
    enable = 1'b1;
  endtask

  task automatic test_arb_loss();
    exp_q.delete();
    push_frame(11'h7FF);
    request(11'h7FF);
    play_bits(2, 1, 3'b111, 1'b0, "arb");
    step();
    checks++;
    if ({arbLost, txDone, bitError, dOut, busy} !== 5'b10011) begin
      failures++;
      $display("FAIL arb_pulse: arbLost/txDone/bitError/dOut/busy got %b want 10011",
               {arbLost, txDone, bitError, dOut, busy});
    end
    step();
    checks++;
    if ({busy, arbLost, dOut} !== 3'b001) begin
      failures++;
      $display("FAIL arb_idle: busy/arbLost/dOut got %b want 001", {busy, arbLost, dOut});
    end
    exp_q.delete();
  endtask

  task automatic test_bit_error();
    exp_q.delete();
    push_frame(11'h555);
    request(11'h555);
    play_bits(1, 0, 3'b111, 1'b1, "sof_err");
    step();
    checks++;
    if ({bitError, arbLost, txDone, dOut} !== 4'b1001) begin
      failures++;
      $display("FAIL sof_err_pulse: bitError/arbLost/txDone/dOut got %b want 1001",
               {bitError, arbLost, txDone, dOut});
    end
    step();
    checks++;
    if ({busy, bitError} !== 2'b00) begin
      failures++;
      $display("FAIL sof_err_idle: busy/bitError got %b want 00", {busy, bitError});
    end
    exp_q.delete();
  endtask

  task automatic test_majority();
    int n;
    exp_q.delete();
    push_frame(11'h555);
    n = exp_q.size();
    request(11'h555);
    play_bits(n, 0, 3'b010, 1'b1, "maj");
    step();
    checks++;
    if ({txDone, bitError, arbLost} !== 3'b100) begin
      failures++;
      $display("FAIL maj_done: txDone/bitError/arbLost got %b want 100",
               {txDone, bitError, arbLost});
    end
    step();
  endtask

  task automatic test_requests();
    logic sent;
    int   n;
    enable = 1'b0;
    id     = 11'h000;
    start  = 1'b1;
    step();
    start  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL disabled_start: busy got %b want 0", busy);
    end
    bit_time(3'b000, 1'b0, sent);
    step();
    checks++;
    if ({sent, busy} !== 2'b10) begin
      failures++;
      $display("FAIL disabled_bus: dOut/busy got %b want 10", {sent, busy});
    end
    exp_q.delete();
    push_frame(11'h555);
    n = exp_q.size();
    request(11'h555);
    play_bits(3, -1, 3'b000, 1'b0, "busy_start");
    step();
    id    = 11'h000;
    start = 1'b1;
    step();
    start = 1'b0;
    play_bits(n - 3, -1, 3'b000, 1'b0, "busy_start");
    step();
    checks++;
    if ({txDone, bitError, arbLost} !== 3'b100) begin
      failures++;
      $display("FAIL busy_start_done: txDone/bitError/arbLost got %b want 100",
               {txDone, bitError, arbLost});
    end
    step();
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    push_frame(11'h555);
    request(11'h555);
    play_bits(3, -1, 3'b000, 1'b0, "rst_mid");
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({dOut, busy, txDone, arbLost, bitError} !== 5'b10000) begin
      failures++;
      $display("FAIL rst_mid: dOut/busy/pulses got %b want 10000",
               {dOut, busy, txDone, arbLost, bitError});
    end
    exp_q.delete();
    step();
    test_frame(11'h555, "after_reset");
  endtask

  initial begin
    test_reset();
    test_frame(11'h555, "clean");
    test_frame(11'h000, "stuff");
    test_frame(11'h01F, "trail");
    test_arb_loss();
    test_bit_error();
    test_majority();
    test_requests();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
